// File: rtl/rom_loader_pkg.sv
// Shared types, per-game region tables and helpers for the table-driven ROM loader.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    localparam int TBL_NREG = 9;
    localparam int TBL_AW   = 26;

    localparam int R_68K      = 0;
    localparam int R_Z80      = 1;
    localparam int R_TILES    = 2;
    localparam int R_SPRITES  = 3;
    localparam int R_007232   = 4;
    localparam int R_THEME    = 5;
    localparam int R_PROM1    = 6;
    localparam int R_PROM2    = 7;
    localparam int R_UPD7759C = 8;

    // Packed tables, region 8 in the MSBs down to region 0 in the LSBs.
    localparam logic [TBL_NREG*TBL_AW-1:0] TMNT_REG_BASE = {
        26'h0408200, 26'h0408100, 26'h0408000, 26'h0388000, 26'h0368000,
        26'h0168000, 26'h0068000, 26'h0060000, 26'h0000000
    };
    localparam logic [TBL_NREG*TBL_AW-1:0] TMNT_REG_SIZE = {
        26'h0020000, 26'h0000100, 26'h0000100, 26'h0080000, 26'h0020000,
        26'h0200000, 26'h0100000, 26'h0008000, 26'h0060000
    };
    localparam logic [TBL_NREG-1:0] TMNT_REG_SWAP = 9'b0_0000_0001;

    // MIA has no theme or UPD7759C ROM; those regions sit at the top of the address space.
    localparam logic [TBL_NREG*TBL_AW-1:0] MIA_REG_BASE = {
        26'h3FFFFFC, 26'h01A8100, 26'h01A8000, 26'h3FFFFFE, 26'h0188000,
        26'h0088000, 26'h0048000, 26'h0040000, 26'h0000000
    };
    localparam logic [TBL_NREG*TBL_AW-1:0] MIA_REG_SIZE = {
        26'h0000002, 26'h0000100, 26'h0000100, 26'h0000002, 26'h0020000,
        26'h0100000, 26'h0040000, 26'h0008000, 26'h0040000
    };
    localparam logic [TBL_NREG-1:0] MIA_REG_SWAP = 9'b0_0000_0001;

    function automatic logic [15:0] swap16(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/rom_loader_gen_if.sv
// Write-side bus between the loader and the SDRAM/BRAM writers.
interface rom_loader_gen_if #(
    parameter int NREG = 9,
    parameter int AW   = 26
) ();
    logic            wr_req;
    logic            wr_ack;
    logic [NREG-1:0] wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [15:0]     wr_data;

    modport master (output wr_req, output wr_sel, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_sel, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rom_wr_fifo.sv
// Small synchronous write buffer; storage is not reset, only pointers and count.
module rom_wr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_sys,
    input  logic          nreset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    a_no_overflow:  assert property (@(posedge clk_sys) disable iff (!nreset) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk_sys) disable iff (!nreset) !(pop && empty));

endmodule

// File: rtl/rom_loader_gen.sv
// Decodes the hps_io ioctl download stream into NREG ROM regions and queues the writes.
module rom_loader_gen
    import rom_loader_pkg::*;
#(
    parameter int                 NREG       = 9,
    parameter int                 AW         = 26,
    parameter logic [NREG*AW-1:0] REG_BASE   = '0,
    parameter logic [NREG*AW-1:0] REG_SIZE   = '0,
    parameter logic [NREG-1:0]    REG_SWAP   = '0,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              nreset,
    input  logic              load_en,
    input  logic [AW-1:0]     ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic              ioctl_wr,
    output logic              ioctl_wait,
    rom_loader_gen_if.master  wr,
    output logic              busy,
    output logic              done,
    output logic              err_unmapped,
    output logic [NREG-1:0]   region_done
);
    localparam int FW = NREG + AW + 16;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [AW-1:0] base_of(input int i);
        return REG_BASE[i*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] size_of(input int i);
        return REG_SIZE[i*AW +: AW];
    endfunction

    // One extra bit so base+size cannot wrap at the top of the address space.
    function automatic logic in_region(input int i, input logic [AW-1:0] a);
        logic [AW:0] lo, hi;
        lo = {1'b0, base_of(i)};
        hi = lo + {1'b0, size_of(i)};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    ld_state_e       state, state_n;
    logic            load_en_q, clr_flags;
    logic            acc_p0, hit_p0;
    logic [NREG-1:0] sel_p0;
    logic [AW-1:0]   addr_p0;
    logic [15:0]     data_p0;
    logic            vld_p1;
    logic [NREG-1:0] sel_p1;
    logic [AW-1:0]   addr_p1;
    logic [15:0]     data_p1;
    logic            fifo_pop, fifo_full, fifo_empty, wait_n;
    logic [CW-1:0]   fifo_count;
    logic [FW-1:0]   fifo_head;
    logic [NREG-1:0] head_sel, rd_set;
    logic [AW-1:0]   head_addr;
    logic [15:0]     head_data;

    // p0: accept and region decode; descending scan so the lowest index wins.
    assign acc_p0 = ioctl_wr && load_en && (state == ST_LOAD) && !ioctl_wait;

    always_comb begin
        hit_p0  = 1'b0;
        sel_p0  = '0;
        addr_p0 = '0;
        data_p0 = ioctl_dout;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (in_region(i, ioctl_addr)) begin
                hit_p0    = 1'b1;
                sel_p0    = '0;
                sel_p0[i] = 1'b1;
                addr_p0   = (ioctl_addr - base_of(i)) >> 1;
                data_p0   = REG_SWAP[i] ? swap16(ioctl_dout) : ioctl_dout;
            end
        end
    end

    // p1: decoded write, pushed into the buffer on the following edge.
    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) vld_p1 <= 1'b0;
        else         vld_p1 <= acc_p0 && hit_p0;
    end

    always_ff @(posedge clk_sys) begin
        if (acc_p0) begin
            sel_p1  <= sel_p0;
            addr_p1 <= addr_p0;
            data_p1 <= data_p0;
        end
    end

    rom_wr_fifo #(.W(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
        .clk_sys (clk_sys),
        .nreset  (nreset),
        .push    (vld_p1),
        .pop     (fifo_pop),
        .din     ({sel_p1, addr_p1, data_p1}),
        .dout    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_sel, head_addr, head_data} = fifo_head;
    assign fifo_pop   = !fifo_empty && wr.wr_ack;
    assign wr.wr_req  = !fifo_empty;
    assign wr.wr_sel  = fifo_empty ? '0 : head_sel;
    assign wr.wr_addr = fifo_empty ? '0 : head_addr;
    assign wr.wr_data = fifo_empty ? '0 : head_data;

    always_comb begin
        state_n   = state;
        clr_flags = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (load_en && !load_en_q) begin
                    state_n   = ST_LOAD;
                    clr_flags = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!load_en) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && !vld_p1) begin
                    if (load_en) begin
                        state_n   = ST_LOAD;
                        clr_flags = 1'b1;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Wait looks at next-cycle occupancy, keeping one slot free for the write still in decode.
    always_comb begin
        wait_n = (state_n == ST_DRAIN) ||
                 ((int'(fifo_count) + int'(vld_p1) - int'(fifo_pop) + int'(acc_p0 && hit_p0))
                  >= FIFO_DEPTH - 1);
        rd_set = '0;
        for (int i = 0; i < NREG; i++) begin
            if (fifo_pop && head_sel[i] && (head_addr == AW'((size_of(i) >> 1) - 1'b1)))
                rd_set[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge nreset) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            load_en_q    <= 1'b0;
            ioctl_wait   <= 1'b0;
            err_unmapped <= 1'b0;
            region_done  <= '0;
        end else begin
            state      <= state_n;
            load_en_q  <= load_en;
            ioctl_wait <= wait_n;
            if (clr_flags) begin
                err_unmapped <= 1'b0;
                region_done  <= '0;
            end else begin
                if (acc_p0 && !hit_p0) err_unmapped <= 1'b1;
                region_done <= region_done | rd_set;
            end
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rom_loader_gen.sv
// Directed and randomized bench for rom_loader_gen with a queue-based reference model.
module tb_rom_loader_gen;

    localparam logic [51:0] BASE = {26'h100, 26'h000};
    localparam logic [51:0] SIZE = {26'h080, 26'h100};

    typedef struct packed {
        logic [1:0]  sel;
        logic [25:0] addr;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        load_en = 1'b0;
    logic [25:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        ioctl_wait, busy, done, err_unmapped;
    logic [1:0]  region_done;
    logic        wr_ack = 1'b0;

    rom_loader_gen_if #(.NREG(2), .AW(26)) wrif ();
    assign wrif.wr_ack = wr_ack;

    rom_loader_gen #(
        .NREG(2), .AW(26), .REG_BASE(BASE), .REG_SIZE(SIZE),
        .REG_SWAP(2'b01), .FIFO_DEPTH(4)
    ) dut (
        .clk_sys      (clk),
        .nreset       (nreset),
        .load_en      (load_en),
        .ioctl_addr   (ioctl_addr),
        .ioctl_dout   (ioctl_dout),
        .ioctl_wr     (ioctl_wr),
        .ioctl_wait   (ioctl_wait),
        .wr           (wrif),
        .busy         (busy),
        .done         (done),
        .err_unmapped (err_unmapped),
        .region_done  (region_done)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    int   mbase [2] = '{0, 'h100};
    int   msize [2] = '{'h100, 'h80};
    bit   mswap [2] = '{1'b1, 1'b0};
    ent_t q [$];
    bit   model_load = 1'b0;
    bit   rand_ack = 1'b0;
    logic exp_err = 1'b0;
    logic [1:0] exp_rdone = 2'b00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ack) wr_ack = 1'($urandom_range(0, 1));
    endtask

    // Drives one strobe once ioctl_wait allows and records what the loader should produce.
    task automatic wr(input logic [25:0] a, input logic [15:0] d);
        int   n = 0;
        int   hit = -1;
        ent_t e;
        while (ioctl_wait && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("wait_timeout", ioctl_wait, 0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (model_load) begin
            for (int i = 1; i >= 0; i--)
                if (int'(a) >= mbase[i] && int'(a) < mbase[i] + msize[i]) hit = i;
            if (hit < 0) begin
                exp_err = 1'b1;
            end else begin
                e.sel  = 2'(1 << hit);
                e.addr = 26'((int'(a) - mbase[hit]) / 2);
                e.data = mswap[hit] ? {d[7:0], d[15:8]} : d;
                q.push_back(e);
            end
        end
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_ack = 1'b0;
        wr_ack   = 1'b1;
        while ((wrif.wr_req || q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_wr_req", wrif.wr_req, 0);
    endtask

    // Every pop must match the oldest outstanding expected write.
    always @(negedge clk) begin
        ent_t e;
        if (nreset && wrif.wr_req && wr_ack) begin
            chk("pop_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pop_sel", wrif.wr_sel, e.sel);
                chk("pop_addr", wrif.wr_addr, e.addr);
                chk("pop_data", wrif.wr_data, e.data);
                for (int i = 0; i < 2; i++)
                    if (e.sel[i] && int'(e.addr) == msize[i] / 2 - 1) exp_rdone[i] = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 nreset = 1'b0;
        #1;
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_req", wrif.wr_req, 0);
        chk("rst_flags", {busy, done, err_unmapped, region_done}, 0);
        chk("rst_bus", {wrif.wr_sel, wrif.wr_addr, wrif.wr_data}, 0);
        tick(); tick();
        nreset = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        // Start a load; first write checks the two-cycle latency.
        load_en = 1'b1;
        tick();
        model_load = 1'b1;
        chk("load_busy", busy, 1);
        wr(26'h102, 16'h1234);
        chk("lat_req_c1", wrif.wr_req, 0);
        tick();
        chk("lat_req_c2", wrif.wr_req, 1);
        chk("lat_sel", wrif.wr_sel, 2'b10);
        chk("lat_addr", wrif.wr_addr, 1);
        chk("lat_data", wrif.wr_data, 16'h1234);
        drain();

        // Byte-swapped region.
        wr_ack = 1'b0;
        wr(26'h004, 16'hABCD);
        tick();
        chk("swap_sel", wrif.wr_sel, 2'b01);
        chk("swap_addr", wrif.wr_addr, 2);
        chk("swap_data", wrif.wr_data, 16'hCDAB);
        drain();

        // Unmapped write is dropped and flags the error.
        wr(26'h200, 16'h5555);
        chk("unmap_err", err_unmapped, exp_err);
        tick();
        chk("unmap_no_req_c1", wrif.wr_req, 0);
        tick();
        chk("unmap_no_req_c2", wrif.wr_req, 0);
        chk("unmap_err_sticky", err_unmapped, 1);

        // Backpressure with the consumer stalled.
        wr_ack = 1'b0;
        wr(26'h010, 16'h1111);
        wr(26'h012, 16'h2222);
        chk("bp_wait_after2", ioctl_wait, 0);
        wr(26'h110, 16'h3333);
        chk("bp_wait_after3", ioctl_wait, 1);
        tick();
        chk("bp_wait_hold", ioctl_wait, 1);
        wr_ack = 1'b1;
        for (int i = 0; i < 5; i++) wr(26'($urandom_range(0, 'h17F)), 16'($urandom));
        drain();

        // Drain then done.
        wr_ack = 1'b0;
        wr(26'h020, 16'hA001);
        wr(26'h120, 16'hA002);
        wr(26'h022, 16'hA003);
        load_en = 1'b0;
        model_load = 1'b0;
        tick();
        chk("drain_busy", busy, 1);
        chk("drain_wait", ioctl_wait, 1);
        chk("drain_not_done", done, 0);
        wr_ack = 1'b1;
        n = 0;
        while (wrif.wr_req && n < 20) begin
            tick();
            n++;
        end
        chk("drain_last_pop_done", done, 0);
        chk("drain_last_pop_busy", busy, 1);
        tick();
        chk("done_set", done, 1);
        chk("done_busy", busy, 0);
        chk("done_wait", ioctl_wait, 0);
        chk("done_err", err_unmapped, exp_err);
        chk("done_rdone", region_done, exp_rdone);

        load_en = 1'b1;
        tick();
        model_load = 1'b1;
        exp_err    = 1'b0;
        exp_rdone  = 2'b00;
        chk("reload_done", done, 0);
        chk("reload_err", err_unmapped, exp_err);
        chk("reload_rdone", region_done, exp_rdone);
        chk("reload_busy", busy, 1);

        // Randomized traffic with a randomly stalling consumer.
        rand_ack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wr(26'($urandom_range(0, 'h27F)), 16'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        chk("rand_err", err_unmapped, exp_err);
        chk("rand_rdone", region_done, exp_rdone);

        // Fresh load with a complete region 0 image.
        load_en = 1'b0;
        model_load = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("restart_done", done, 1);
        load_en = 1'b1;
        tick();
        model_load = 1'b1;
        exp_err    = 1'b0;
        exp_rdone  = 2'b00;
        wr_ack = 1'b1;
        for (int a = 0; a <= 'hFE; a += 2) begin
            if (a == 'hFE) chk("r0_not_done_yet", region_done, 2'b00);
            wr(26'(a), 16'($urandom));
        end
        drain();
        chk("r0_region_done", region_done, 2'b01);
        chk("r0_model_rdone", region_done, exp_rdone);
        chk("r0_err", err_unmapped, 0);

        // Reset with writes buffered.
        wr_ack = 1'b0;
        wr(26'h030, 16'hBEEF);
        wr(26'h130, 16'hCAFE);
        tick();
        chk("prerst_req", wrif.wr_req, 1);
        nreset  = 1'b0;
        load_en = 1'b0;
        #1;
        q.delete();
        model_load = 1'b0;
        exp_err    = 1'b0;
        exp_rdone  = 2'b00;
        chk("midrst_req", wrif.wr_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_wait", ioctl_wait, 0);
        chk("midrst_rdone", region_done, exp_rdone);
        chk("midrst_bus", {wrif.wr_sel, wrif.wr_addr, wrif.wr_data}, 0);
        tick();
        nreset = 1'b1;
        tick();
        tick();
        chk("postrst_req", wrif.wr_req, 0);
        chk("postrst_idle", {busy, done}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_loader_gen.md
Name: rom_loader_gen

Overview:
- Table-driven, parametrised successor to the per-game ROM loaders.
- Decodes the 16-bit MiSTer ioctl download stream into NREG ROM regions, using base, size and byte-swap settings from parameters.
- Buffers decoded writes in a small FIFO and hands them to the SDRAM/BRAM writers over a req/ack handshake, with ioctl_wait backpressure.
- Sits between hps_io and the ROM storage. One instance per game table replaces the hand-written loaders.

Parameters:
- NREG, 9: number of ROM regions.
- AW, 26: ioctl byte-address width; also the output word-address width.
- REG_BASE, 0: NREG*AW packed field; start byte offset of region i in the stream (region 0 in the LSBs).
- REG_SIZE, 0: NREG*AW packed field; size of region i in bytes (even, nonzero).
- REG_SWAP, 0: NREG bits; bit i=1 swaps bytes of region i data.
- FIFO_DEPTH, 4: write-buffer entries (power of 2, ≥2).

Ports:
- clk_sys  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- load_en  in  1  download window (ioctl_download & index match)
- ioctl_addr  in  AW  byte address of current word
- ioctl_dout  in  16  download data
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_wait  out  1  backpressure to hps_io
- wr_req  out  1  FIFO head valid
- wr_ack  in  1  consumer accepts head this cycle
- wr_sel  out  NREG  one-hot region select for head
- wr_addr  out  AW  region-relative word address for head
- wr_data  out  16  head data, swapped if configured
- busy  out  1  state is LOAD or DRAIN
- done  out  1  load complete, FIFO empty
- err_unmapped  out  1  sticky: a write hit no region
- region_done  out  NREG  sticky: last word of region i was written

Behaviour:
- Reset (async, nreset=0): state IDLE; FIFO flushed. ioctl_wait, wr_req, busy, done, err_unmapped = 0; wr_sel, wr_addr, wr_data, region_done = 0. Mid-operation reset discards all buffered writes.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE/DONE, load_en rising → LOAD; same edge clears done, err_unmapped, region_done.
  - LOAD, load_en=0 → DRAIN.
  - DRAIN, FIFO empty → DONE (done=1).
  - DRAIN with load_en=1 when it empties → LOAD, flags cleared; DONE is skipped.
- Accept: ioctl_wr & load_en & state==LOAD & !ioctl_wait. Strobes in any other state are ignored.
- Decode stage (1 register, 1 cycle):
  - hit_i = ioctl_addr ≥ BASE_i && ioctl_addr < BASE_i+SIZE_i, compared at AW+1 bits so there is no overflow.
  - Overlapping hits: lowest index wins.
  - addr = (ioctl_addr − BASE_i) >> 1; ioctl_addr[0] is ignored.
  - data = REG_SWAP[i] ? {dout[7:0],dout[15:8]} : dout.
  - No hit → err_unmapped set; the write is dropped, no FIFO push.
- FIFO push occurs the cycle after accept. Latency from ioctl_wr to wr_req = 2 cycles with FIFO empty.
- Pop when wr_req & wr_ack. A push and a pop in the same cycle leave the count unchanged.
- wr_sel/addr/data are stable while wr_req=1 and !wr_ack. The consumer may hold wr_ack high continuously.
- ioctl_wait:
  - 1 when count + decode_valid ≥ FIFO_DEPTH−1, which reserves a slot for the in-flight decode entry.
  - Also 1 in DRAIN.
  - Registered, so the FIFO never overflows. Overflow is a design error and must be asserted against in simulation.
- region_done[i] sets on a pop whose wr_addr == SIZE_i/2 − 1 with wr_sel[i].
- busy = (state==LOAD || state==DRAIN).

Decomposition:
- rom_loader_pkg:
  - FSM state enum.
  - Region-table constants for TMNT and MIA: REG_BASE, REG_SIZE, REG_SWAP packed values.
  - Region index localparams (R_68K, R_Z80, R_TILES, R_SPRITES, R_007232, R_THEME, R_PROM1, R_PROM2, R_UPD7759C).
- Sub-module rom_wr_fifo:
  - Synchronous FIFO with async active-low reset.
  - Width AW+NREG+16, depth FIFO_DEPTH.
  - Exposes count, full, empty, push and pop ports.
- Per-game selection stays one level up: a mux of two rom_loader_gen instances, or one instance per tno.

Test Plan:
- NREG=2, BASE={0x0,0x100}, SIZE={0x100,0x80}: write addr 0x102, data 0x1234 → 2 cycles later wr_req=1, wr_sel=2'b10, wr_addr=1, wr_data=0x1234.
- REG_SWAP[0]=1: write addr 0x4, data 0xABCD → wr_sel=01, wr_addr=2, wr_data=0xCDAB.
- Write addr 0x200 (unmapped) → no wr_req; err_unmapped=1 and stays 1 until the next load_en rise.
- Hold wr_ack=0 and stream 8 strobes → ioctl_wait rises after the 3rd accept (DEPTH=4). Then wr_ack=1 → all mapped writes pop in order, none lost or duplicated.
- Drop load_en with 3 entries queued → busy=1 through DRAIN, done=1 one cycle after last pop. Re-raise load_en → done, region_done, err_unmapped = 0.
- Full region 0 stream (0x0..0xFE) → region_done[0]=1 on the pop with wr_addr=0x7F. Pulse nreset=0 mid-stream → wr_req=0 immediately, state IDLE, FIFO empty.
